// File: rtl/bmem_adapter.sv
// bmem_adapter
//   Arbiter and burst engine between the I-cache / D-cache line ports and the
//   banked-memory (bmem) port. It handles one transaction at a time.
//   A line read is one bmem read command. Its four 64-bit return beats are
//   assembled into a 256-bit line. A line write is sent as four 64-bit beats.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   icache_addr/read              I-cache line read request
//   icache_rdata/resp             I-cache line data and one-cycle completion
//   dcache_addr/read/write/wdata  D-cache line read or write request
//   dcache_rdata/resp             D-cache line data and one-cycle completion
//   bmem_addr/read/write/wdata    command / write-beat outputs (registered)
//   bmem_ready                    memory accepts the command or beat
//   bmem_raddr/rdata/rvalid       read return beats
module bmem_adapter #(
  parameter int unsigned BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  icache_addr,
  input  logic         icache_read,
  output logic [255:0] icache_rdata,
  output logic         icache_resp,
  input  logic [31:0]  dcache_addr,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [255:0] dcache_wdata,
  output logic [255:0] dcache_rdata,
  output logic         dcache_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t       state;
  logic [1:0]   beat;
  logic [1:0]   next_beat;
  logic         src_d;        // granted source: 1 = D-cache
  logic         last_grant;   // 1 = D-cache was granted last
  logic [255:0] line;         // write data or partially assembled read line
  logic [255:0] assembled;    // line with the current return beat merged in
  logic         d_req;
  logic         i_req;
  logic         grant_d;
  logic         beat_hit;
  logic         unused;

  always_comb begin
    d_req     = dcache_read | dcache_write;
    i_req     = icache_read;
    // On a tie the source that was not granted last wins.
    grant_d   = d_req & (~i_req | ~last_grant);
    next_beat = beat + 2'd1;
    beat_hit  = bmem_rvalid && (bmem_raddr == bmem_addr);
    assembled = line;
    assembled[64*beat +: 64] = bmem_rdata;
    unused    = ^{icache_addr[4:0], dcache_addr[4:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      src_d        <= 1'b0;
      last_grant   <= 1'b0;
      line         <= '0;
      bmem_addr    <= '0;
      bmem_read    <= 1'b0;
      bmem_write   <= 1'b0;
      bmem_wdata   <= '0;
      icache_resp  <= 1'b0;
      dcache_resp  <= 1'b0;
      icache_rdata <= '0;
      dcache_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            src_d      <= grant_d;
            last_grant <= grant_d;
            beat       <= '0;
            bmem_addr  <= grant_d ? {dcache_addr[31:5], 5'b0} : {icache_addr[31:5], 5'b0};
            // A D-cache request with write high is a write, even if read is also high.
            if (grant_d && dcache_write) begin
              line       <= dcache_wdata;
              bmem_write <= 1'b1;
              bmem_wdata <= dcache_wdata[63:0];
              state      <= WR_BURST;
            end else begin
              bmem_read <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (beat_hit) begin
            line <= assembled;
            beat <= next_beat;
            if (beat == LAST_BEAT) begin
              state <= RESP;
              if (src_d) begin
                dcache_rdata <= assembled;
                dcache_resp  <= 1'b1;
              end else begin
                icache_rdata <= assembled;
                icache_resp  <= 1'b1;
              end
            end
          end
        end

        WR_BURST: begin
          if (bmem_ready) begin
            if (beat == LAST_BEAT) begin
              bmem_write  <= 1'b0;
              dcache_resp <= 1'b1;
              state       <= RESP;
            end else begin
              beat       <= next_beat;
              bmem_wdata <= line[64*next_beat +: 64];
            end
          end
        end

        RESP: begin
          icache_resp <= 1'b0;
          dcache_resp <= 1'b0;
          beat        <= '0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
